// File: rtl/alu_issue_arbiter_if.sv
// Requester/ALU/response bundle for alu_issue_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_issue_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned IdWidth = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*4-1:0]          req_opcode;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;

  logic [3:0]                    alu_opcode;
  logic [DATA_WIDTH-1:0]         alu_a;
  logic [DATA_WIDTH-1:0]         alu_b;
  logic [DATA_WIDTH-1:0]         alu_result;
  logic [4:0]                    alu_flags;

  logic [NUM_REQ-1:0]            rsp_valid;
  logic [IdWidth-1:0]            rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_result;
  logic [4:0]                    rsp_flags;
  logic                          rsp_err;
  logic                          busy;

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_result, alu_flags,
    input  req_ready, alu_opcode, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_result, alu_flags,
    output req_ready, alu_opcode, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between NUM_REQ requesters: arbitrate, run the op for its latency, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_arbiter_if.slave bus
);
  localparam int unsigned IdWidth  = $clog2(NUM_REQ);
  localparam int unsigned MaxLat   = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntWidth = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [3:0]  OpDiv    = 4'b0010;
  localparam logic [3:0]  OpMul    = 4'b0011;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [IdWidth-1:0]    id_q, id_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [4:0]            flags_q, flags_d;
  logic                  err_q, err_d;

  logic [IdWidth-1:0]    winner;
  logic                  handshake;
  logic [3:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [CntWidth-1:0]   sel_cnt;

  assign handshake = (state_q == StIdle) && (bus.req_valid != '0);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) winner = IdWidth'(i);
    end
  end
`else
  logic [IdWidth-1:0] ptr_q;
  logic [NUM_REQ-1:0] above_ptr, masked, pool;

  // Prefer requesters above the last grant; wrap to the full set if none are valid there.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) above_ptr[i] = (i > int'(ptr_q));
    masked = bus.req_valid & above_ptr;
    pool   = (masked != '0) ? masked : bus.req_valid;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pool[i]) winner = IdWidth'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IdWidth'(NUM_REQ - 1);
    end else if (handshake) begin
      ptr_q <= winner;
    end
  end
`endif

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IdWidth'(i)) begin
        sel_op = bus.req_opcode[4*i +: 4];
        sel_a  = bus.req_a[DATA_WIDTH*i +: DATA_WIDTH];
        sel_b  = bus.req_b[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
    if (sel_op == OpMul)      sel_cnt = CntWidth'(MUL_CYCLES - 1);
    else if (sel_op == OpDiv) sel_cnt = CntWidth'(DIV_CYCLES - 1);
    else                      sel_cnt = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (handshake) begin
          id_d = winner;
          // Error ops never reach the ALU registers, so the ALU keeps its previous operation.
          if (sel_op >= 4'hE) begin
            res_d   = '0;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else if (sel_op == OpDiv && sel_b == '0) begin
            res_d   = '1;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            cnt_d   = sel_cnt;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          res_d   = bus.alu_result;
          flags_d = bus.alu_flags;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (handshake) bus.req_ready[winner] = 1'b1;
    bus.rsp_valid = '0;
    if (state_q == StResp) bus.rsp_valid[id_q] = 1'b1;
  end

  assign bus.alu_opcode = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = (state_q != StIdle);
endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single CPU ALU between NUM_REQ requesters (fetch/decode, address generation, debug, and similar units). Each request carries a 4-bit ALU opcode and two operands. The block grants one requester at a time, latches the operands, and drives the ALU for the opcode's fixed latency. It then returns the result and the 5-bit flag struct (carry, zero, equal, larger, lower; MSB first) to the winning requester. It sits between the requesters and the ALU, and owns all multi-cycle sequencing for MUL and DIV.

## Interface
- NUM_REQ, 4 — number of requesters, 2..8
- DATA_WIDTH, 16 — operand/result width
- MUL_CYCLES, 4 — ALU cycles for opcode 0011 (MUL), ≥1
- DIV_CYCLES, 16 — ALU cycles for opcode 0010 (DIV), ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_opcode  in  NUM_REQ*4  packed opcodes, requester i at [4i+3:4i]
- req_a, req_b  in  NUM_REQ*DATA_WIDTH  packed operands
- alu_opcode  out  4  to ALU
- alu_a, alu_b  out  DATA_WIDTH  to ALU, held stable during execution
- alu_result  in  DATA_WIDTH  from ALU
- alu_flags  in  5  from ALU
- rsp_valid  out  NUM_REQ  one-hot, single-cycle response strobe
- rsp_id  out  $clog2(NUM_REQ)  index of the responding requester
- rsp_result  out  DATA_WIDTH  result
- rsp_flags  out  5  flags
- rsp_err  out  1  illegal opcode or divide by zero
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready[w] = 1 combinationally for the arbitration winner w, and only while req_valid[w] = 1.
  - On the handshake edge: latch opcode, a, b and w.
  - Legal op with no error: load cnt = latency−1 and go to EXEC.
  - Error case: go straight to RESP.
- Latency per opcode: MUL = MUL_CYCLES, DIV = DIV_CYCLES, all other legal opcodes (0000–1101) = 1.
- Errors, which bypass EXEC (the ALU is not driven with the op):
  - Opcodes 1110 and 1111: rsp_err = 1, result 0, flags 0.
  - DIV with b == 0: rsp_err = 1, result all-ones, flags 0.
- EXEC:
  - alu_* outputs come from the latched registers.
  - When cnt == 0: capture alu_result and alu_flags into the rsp registers, then go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - rsp_valid[w] = 1 for exactly one cycle, with rsp_id = w.
  - rsp_result, rsp_flags and rsp_err are valid in this cycle and hold until the next response.
  - There is no response backpressure.
  - Next state is IDLE.
- No request is accepted in EXEC or RESP; req_ready = 0 in both.
- Arbitration is round-robin by default.
  - A pointer holds the last granted index; search starts at last+1 modulo NUM_REQ.
  - The pointer updates only on a handshake.
  - Reset value is NUM_REQ−1, so requester 0 has top priority first.
- When idle, alu_opcode/alu_a/alu_b hold their last values. Upstream ignores them.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, rsp_err 0, alu_opcode 0, alu_a 0, alu_b 0, busy 0, state IDLE, RR pointer NUM_REQ−1.
- Legal op handshake at edge E:
  - EXEC occupies L cycles after E.
  - rsp_valid is high in cycle L+1 after E.
  - The next handshake is possible at edge E+L+2.
- Single-cycle op throughput: one result every 3 cycles.
- Error op: rsp_valid is high in the cycle after E; next accept at E+2.
- req_valid may drop without a handshake; no state changes.
- Requester payloads are sampled only on the handshake edge.
- rst_n asserted mid-EXEC or RESP: all state clears immediately. The aborted op produces no rsp_valid, ever.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest-index valid requester always wins, and the RR pointer is not implemented.
  - Undefined: round-robin as described above.

## Test plan
- Reset then single ADD: requester 0 sends a = 16'h0003, b = 16'h0004 → req_ready[0] is high in the same cycle. Two cycles after the handshake: rsp_valid = 4'b0001, rsp_id 0, rsp_result 16'h0007, rsp_flags equal to alu_flags, rsp_err 0.
- MUL latency: opcode 0011 with a = 5, b = 6 → alu_a/alu_b held at 5/6 for 4 cycles. rsp_valid arrives 5 cycles after the handshake with result 30. req_ready stays 0 throughout.
- Divide by zero: DIV with a = 9, b = 0 → rsp_valid the next cycle, rsp_err 1, result 16'hFFFF, flags 0, and the ALU opcode is never driven to 0010 for this op.
- Illegal opcode 4'b1111 → rsp_err 1, result 0, one-cycle turnaround.
- Round-robin with all 4 req_valid held high and single-cycle ops → grant order 0, 1, 2, 3, 0. With the macro defined, the same stimulus grants 0 every time.
- Reset during a DIV at EXEC cycle 8 → all outputs return to their reset values. No rsp_valid follows. After release, a new ADD from requester 2 completes normally.
